// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch button front end.
package stopwatch_pkg;

  localparam int N_DEFAULT = 20;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  // Debounced level is high while settled high or while confirming a release.
  function automatic logic db_is_high(input db_state_e s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/debounce.sv
// One button channel: 2-FF synchroniser, debounce FSM with N-bit down-counter,
// and a registered one-cycle rise tick.
//
// state | meaning
// ZERO  | settled low
// WAIT1 | input high, counting down the stable window before accepting
// ONE   | settled high
// WAIT0 | input low, counting down the stable window before releasing
module debounce
  import stopwatch_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  logic          sync1_q;
  logic          sync2_q;
  db_state_e     state_q;
  db_state_e     state_d;
  logic [N-1:0]  cnt_q;
  logic [N-1:0]  cnt_d;
  logic          tick_q;
  logic          tick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sync2_q) begin
          state_d = WAIT1;
          cnt_d   = '1;
        end
      end
      WAIT1: begin
        if (!sync2_q) begin
          state_d = ZERO;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - N'(1);
        end else begin
          state_d = ONE;
          tick_d  = 1'b1;
        end
      end
      ONE: begin
        if (!sync2_q) begin
          state_d = WAIT0;
          cnt_d   = '1;
        end
      end
      WAIT0: begin
        if (sync2_q) begin
          state_d = ONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - N'(1);
        end else begin
          state_d = ZERO;
        end
      end
    endcase
  end

  assign db_level = db_is_high(state_q);
  assign db_tick  = tick_q;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Conditions the go/back/clear buttons into stopwatch control levels and a
// one-cycle clear pulse.
module stopwatch_btn_ctrl
  import stopwatch_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_go,
  input  logic btn_back,
  input  logic btn_clr,
  output logic go,
  output logic back,
  output logic clr,
  output logic db_go,
  output logic db_back,
  output logic db_clr
);

  logic go_tick;
  logic back_tick;
  logic clr_tick;
  logic go_q;
  logic go_d;
  logic back_q;
  logic back_d;
  logic clr_q;
  logic clr_d;

  debounce #(.N(N)) u_db_go (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (btn_go),
    .db_level (db_go),
    .db_tick  (go_tick)
  );

  debounce #(.N(N)) u_db_back (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (btn_back),
    .db_level (db_back),
    .db_tick  (back_tick)
  );

  debounce #(.N(N)) u_db_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (btn_clr),
    .db_level (db_clr),
    .db_tick  (clr_tick)
  );

  // Clear wins over any simultaneous go/back press.
  always_comb begin
    clr_d  = clr_tick;
    go_d   = go_q ^ go_tick;
    back_d = back_q ^ back_tick;
    if (clr_tick) begin
      go_d   = 1'b0;
      back_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_q   <= 1'b0;
      back_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      go_q   <= go_d;
      back_q <= back_d;
      clr_q  <= clr_d;
    end
  end

  assign go   = go_q;
  assign back = back_q;
  assign clr  = clr_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Bench for stopwatch_btn_ctrl with N=4: directed scenarios plus random
// button activity, all outputs compared every cycle against a stability model.
module tb_stopwatch_btn_ctrl;

  localparam int N   = 4;
  localparam int WIN = (1 << N) + 1;

  logic clk      = 1'b0;
  logic reset_n  = 1'b1;
  logic btn_go   = 1'b0;
  logic btn_back = 1'b0;
  logic btn_clr  = 1'b0;
  logic go, back, clr, db_go, db_back, db_clr;

  int total   = 0;
  int bad     = 0;
  int clr_cnt = 0;

  stopwatch_btn_ctrl #(.N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_go   (btn_go),
    .btn_back (btn_back),
    .btn_clr  (btn_clr),
    .go       (go),
    .back     (back),
    .clr      (clr),
    .db_go    (db_go),
    .db_back  (db_back),
    .db_clr   (db_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a button level flips once the synchronised input has disagreed
  // with it for WIN consecutive samples; the synchroniser is a 2-sample delay.
  logic [2:0] raw;
  assign raw = {btn_clr, btn_back, btn_go};

  logic m_d1 [3]   = '{1'b0, 1'b0, 1'b0};
  logic m_d2 [3]   = '{1'b0, 1'b0, 1'b0};
  logic m_lvl [3]  = '{1'b0, 1'b0, 1'b0};
  logic m_tick [3] = '{1'b0, 1'b0, 1'b0};
  int   m_run [3]  = '{0, 0, 0};
  logic m_go   = 1'b0;
  logic m_back = 1'b0;
  logic m_clr  = 1'b0;
  logic m_s;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_lvl[b] = 1'b0;
        m_tick[b] = 1'b0; m_run[b] = 0;
      end
      m_go = 1'b0; m_back = 1'b0; m_clr = 1'b0;
    end else begin
      m_clr = m_tick[2];
      if (m_tick[2]) begin
        m_go = 1'b0;
        m_back = 1'b0;
      end else begin
        m_go   = m_go ^ m_tick[0];
        m_back = m_back ^ m_tick[1];
      end
      for (int b = 0; b < 3; b++) begin
        m_s = m_d2[b];
        m_tick[b] = 1'b0;
        if (m_s == m_lvl[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == WIN) begin
            m_lvl[b]  = m_s;
            m_run[b]  = 0;
            m_tick[b] = m_s;
          end
        end
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("sb_go", go, m_go);
    chk("sb_back", back, m_back);
    chk("sb_clr", clr, m_clr);
    chk("sb_db_go", db_go, m_lvl[0]);
    chk("sb_db_back", db_back, m_lvl[1]);
    chk("sb_db_clr", db_clr, m_lvl[2]);
    if (clr) clr_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_chk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every button held.
    #1;
    reset_n = 1'b0;
    btn_go = 1'b1; btn_back = 1'b1; btn_clr = 1'b1;
    edge_chk(3);
    chk("rst_go", go, 0);
    chk("rst_back", back, 0);
    chk("rst_clr", clr, 0);
    chk("rst_db_go", db_go, 0);
    chk("rst_db_back", db_back, 0);
    chk("rst_db_clr", db_clr, 0);
    @(negedge clk);
    btn_back = 1'b0; btn_clr = 1'b0; reset_n = 1'b1;
    edge_chk(19);
    chk("rel_go_e18", go, 0);
    chk("rel_db_go_e18", db_go, 1);
    edge_chk(1);
    chk("rel_go_e19", go, 1);
    chk("rel_clr_e19", clr, 0);
    @(negedge clk); btn_go = 1'b0;
    idle(30);

    // Second clean press toggles go back to 0.
    btn_go = 1'b1;
    edge_chk(19);
    chk("press_db_e18", db_go, 1);
    chk("press_go_e18", go, 1);
    edge_chk(1);
    chk("press_go_e19", go, 0);
    idle(20);
    btn_go = 1'b0;
    idle(30);

    // Bounce on back is rejected; a long hold toggles once.
    btn_back = 1'b1; idle(10);
    btn_back = 1'b0; idle(3);
    btn_back = 1'b1; idle(12);
    chk("bounce_back", back, 0);
    chk("bounce_db_back", db_back, 0);
    idle(20);
    chk("hold_back", back, 1);
    btn_back = 1'b0;
    idle(30);

    btn_go = 1'b1; idle(25);
    btn_go = 1'b0; idle(25);
    chk("pre_clr_go", go, 1);
    chk("pre_clr_back", back, 1);

    // Simultaneous go + clear: clear wins.
    btn_go = 1'b1; btn_clr = 1'b1; clr_cnt = 0;
    edge_chk(20);
    chk("prio_clr_e19", clr, 1);
    chk("prio_go_e19", go, 0);
    chk("prio_back_e19", back, 0);
    edge_chk(1);
    chk("prio_clr_e20", clr, 0);
    @(negedge clk);
    btn_go = 1'b0; btn_clr = 1'b0;
    idle(30);
    chk("prio_clr_pulses", clr_cnt, 1);
    chk("prio_go_after", go, 0);

    // Release of clear produces nothing.
    btn_clr = 1'b1; clr_cnt = 0;
    begin : wait_db
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #2;
        if (db_clr) disable wait_db;
      end
    end
    chk("db_clr_wait", db_clr, 1);
    @(negedge clk); btn_clr = 1'b0;
    edge_chk(18);
    chk("clr_rel_db_e17", db_clr, 1);
    edge_chk(1);
    chk("clr_rel_db_e18", db_clr, 0);
    idle(20);
    chk("clr_rel_pulses", clr_cnt, 1);

    // Async reset in the middle of a go window.
    @(negedge clk); btn_go = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst_go", go, 0);
    chk("midrst_db_go", db_go, 0);
    chk("midrst_clr", clr, 0);
    @(negedge clk); reset_n = 1'b1;
    edge_chk(19);
    chk("midrst_go_e18", go, 0);
    edge_chk(1);
    chk("midrst_go_e19", go, 1);
    @(negedge clk); btn_go = 1'b0;
    idle(30);

    // Random activity with occasional resets; the model checks every cycle.
    for (int ep = 0; ep < 120; ep++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      btn_go = v[0]; btn_back = v[1]; btn_clr = v[2];
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        idle($urandom_range(1, 3));
        reset_n = 1'b1;
      end
      idle($urandom_range(1, 40));
    end
    btn_go = 1'b0; btn_back = 1'b0; btn_clr = 1'b0;
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
